// File: rtl/vit_pkg.sv
// Shared ViT datapath definitions: Q8.8 format limits, residual-adder FSM states
// and the saturating Q8.8 add used by the residual and MLP bias adders.
package vit_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned Q_FRAC = 8;
    localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        ADD
    } resadd_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] y;
        logic              sat;
    } sat_res_t;

    // A 17-bit sum whose top two bits differ has left the 16-bit range.
    function automatic sat_res_t sat_add_q88(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sat_res_t        res;
        sum     = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        res.y   = sum[DATA_W-1:0];
        res.sat = 1'b0;
        if (!sum[DATA_W] && sum[DATA_W-1]) begin
            res.y   = Q_MAX;
            res.sat = 1'b1;
        end else if (sum[DATA_W] && !sum[DATA_W-1]) begin
            res.y   = Q_MIN;
            res.sat = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_add_q88.sv
// Combinational saturating Q8.8 adder; the sat flag marks a clamped result.
module sat_add_q88 (
    input  logic [vit_pkg::DATA_W-1:0] a,
    input  logic [vit_pkg::DATA_W-1:0] b,
    output logic [vit_pkg::DATA_W-1:0] y,
    output logic                       sat
);

    vit_pkg::sat_res_t res;

    always_comb begin
        res = vit_pkg::sat_add_q88(a, b);
    end

    assign y   = res.y;
    assign sat = res.sat;

endmodule

// File: rtl/residual_add_stream.sv
// Residual adder: buffers one skip-path token vector, then streams the saturated
// element-wise sum with the sublayer output to LayerNorm.
module residual_add_stream #(
    parameter int unsigned EMBED_DIM = 384,
    parameter int unsigned DATA_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [DATA_W-1:0]            skip_in,
    input  logic                         skip_in_v,
    input  logic [DATA_W-1:0]            branch_in,
    input  logic                         branch_in_v,
    output logic [DATA_W-1:0]            vec_out,
    output logic                         vec_out_v,
    output logic                         ln_start,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(EMBED_DIM):0]   sat_count
);

    import vit_pkg::resadd_state_t;
    import vit_pkg::IDLE;
    import vit_pkg::CAPTURE;
    import vit_pkg::ADD;

    localparam int unsigned IW = $clog2(EMBED_DIM);
    localparam int unsigned CW = IW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(EMBED_DIM - 1);

    resadd_state_t     state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] vec_out_q, vec_out_d;
    logic              vec_out_v_q, vec_out_v_d;
    logic              ln_start_q, ln_start_d;
    logic              done_q, done_d;
    logic [CW-1:0]     sat_count_q, sat_count_d;
    logic              buf_we;

    logic [DATA_W-1:0] skip_buf [EMBED_DIM];
    logic [DATA_W-1:0] skip_rd;
    logic [DATA_W-1:0] sum_y;
    logic              sum_sat;

    // Single-port buffer: written during CAPTURE, read during ADD, same address.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            skip_buf[idx_q] <= skip_in;
        end
    end

    assign skip_rd = skip_buf[idx_q];

    sat_add_q88 u_sat_add (
        .a   (skip_rd),
        .b   (branch_in),
        .y   (sum_y),
        .sat (sum_sat)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        vec_out_d   = vec_out_q;
        vec_out_v_d = 1'b0;
        ln_start_d  = 1'b0;
        done_d      = 1'b0;
        sat_count_d = sat_count_q;
        buf_we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                if (start) begin
                    state_d     = CAPTURE;
                    sat_count_d = '0;
                end
            end
            CAPTURE: begin
                if (skip_in_v) begin
                    buf_we = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d      = '0;
                        state_d    = ADD;
                        ln_start_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            ADD: begin
                if (branch_in_v) begin
                    vec_out_d   = sum_y;
                    vec_out_v_d = 1'b1;
                    if (sum_sat) begin
                        sat_count_d = sat_count_q + CW'(1);
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            vec_out_q   <= '0;
            vec_out_v_q <= 1'b0;
            ln_start_q  <= 1'b0;
            done_q      <= 1'b0;
            sat_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            vec_out_q   <= vec_out_d;
            vec_out_v_q <= vec_out_v_d;
            ln_start_q  <= ln_start_d;
            done_q      <= done_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign vec_out   = vec_out_q;
    assign vec_out_v = vec_out_v_q;
    assign ln_start  = ln_start_q;
    assign done      = done_q;
    assign sat_count = sat_count_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_residual_add_stream.sv
// Bench for residual_add_stream with EMBED_DIM=4: directed and random vectors checked
// against a plain-arithmetic saturating-sum model.
module tb_residual_add_stream;

    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;
    localparam logic [15:0] ONE = 16'(1 << vit_pkg::Q_FRAC);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   skip_in = '0;
    logic          skip_in_v = 1'b0;
    logic [15:0]   branch_in = '0;
    logic          branch_in_v = 1'b0;
    logic [15:0]   vec_out;
    logic          vec_out_v;
    logic          ln_start;
    logic          busy;
    logic          done;
    logic [CW-1:0] sat_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] sv [D];
    logic [15:0] bv [D];

    residual_add_stream #(
        .EMBED_DIM (D),
        .DATA_W    (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .skip_in     (skip_in),
        .skip_in_v   (skip_in_v),
        .branch_in   (branch_in),
        .branch_in_v (branch_in_v),
        .vec_out     (vec_out),
        .vec_out_v   (vec_out_v),
        .ln_start    (ln_start),
        .busy        (busy),
        .done        (done),
        .sat_count   (sat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer sum, clamped to the 16-bit signed range.
    function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                            output bit clamped);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        clamped = 1'b0;
        if (s > 32767) begin
            clamped = 1'b1;
            return 16'h7FFF;
        end
        if (s < -32768) begin
            clamped = 1'b1;
            return 16'h8000;
        end
        return 16'(s);
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_vec_out"}, 32'(vec_out), 32'h0);
        chk({tag, "_vec_out_v"}, 32'(vec_out_v), 32'h0);
        chk({tag, "_ln_start"}, 32'(ln_start), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_sat_count"}, 32'(sat_count), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    task automatic start_vec(input bit already);
        if (!already) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'h1);
        chk("sat_cleared_on_start", 32'(sat_count), 32'h0);
    endtask

    task automatic capture(input bit gaps, input bit strays);
        for (int i = 0; i < D; i++) begin
            skip_in     = sv[i];
            skip_in_v   = 1'b1;
            branch_in   = 16'($urandom);
            branch_in_v = strays ? 1'($urandom) : 1'b0;
            start       = strays ? 1'($urandom) : 1'b0;
            @(negedge clk);
            skip_in_v   = 1'b0;
            branch_in_v = 1'b0;
            start       = 1'b0;
            chk("capture_vec_out_v", 32'(vec_out_v), 32'h0);
            chk("capture_done", 32'(done), 32'h0);
            if (i != D - 1) begin
                chk("capture_ln_start", 32'(ln_start), 32'h0);
                if (gaps) begin
                    @(negedge clk);
                    chk("capture_gap_busy", 32'(busy), 32'h1);
                end
            end
        end
        chk("ln_start_pulse", 32'(ln_start), 32'h1);
        chk("add_busy", 32'(busy), 32'h1);
    endtask

    task automatic add_phase(input bit gaps, input bit strays, input bit chain);
        int          exp_sat;
        logic [15:0] e;
        bit          clamped;
        exp_sat = 0;
        for (int i = 0; i < D; i++) begin
            branch_in   = bv[i];
            branch_in_v = 1'b1;
            skip_in     = 16'($urandom);
            skip_in_v   = strays ? 1'($urandom) : 1'b0;
            start       = strays ? 1'($urandom) : 1'b0;
            e = ref_sum(sv[i], bv[i], clamped);
            if (clamped) exp_sat++;
            @(negedge clk);
            branch_in_v = 1'b0;
            skip_in_v   = 1'b0;
            start       = 1'b0;
            chk($sformatf("vec_out[%0d]", i), 32'(vec_out), 32'(e));
            chk($sformatf("vec_out_v[%0d]", i), 32'(vec_out_v), 32'h1);
            chk($sformatf("sat_count[%0d]", i), 32'(sat_count), 32'(exp_sat));
            chk($sformatf("done[%0d]", i), 32'(done), 32'(i == D - 1));
            chk($sformatf("ln_start_low[%0d]", i), 32'(ln_start), 32'h0);
            chk($sformatf("busy[%0d]", i), 32'(busy), 32'(i != D - 1));
            if (i == D - 1 && chain) start = 1'b1;
            if (gaps && i != D - 1) begin
                skip_in   = 16'($urandom);
                skip_in_v = strays;
                @(negedge clk);
                skip_in_v = 1'b0;
                chk("gap_vec_out_v", 32'(vec_out_v), 32'h0);
                chk("gap_vec_out_hold", 32'(vec_out), 32'(e));
                chk("gap_done", 32'(done), 32'h0);
            end
        end
        if (!chain) begin
            @(negedge clk);
            chk("post_busy", 32'(busy), 32'h0);
            chk("post_vec_out_v", 32'(vec_out_v), 32'h0);
            chk("post_done", 32'(done), 32'h0);
            chk("post_sat_hold", 32'(sat_count), 32'(exp_sat));
        end
    endtask

    task automatic run_vec(input bit gaps, input bit strays, input bit chain_in,
                           input bit chain_out);
        start_vec(chain_in);
        capture(gaps, strays);
        add_phase(gaps, strays, chain_out);
    endtask

    task automatic fill_random(input bit wide);
        for (int i = 0; i < D; i++) begin
            sv[i] = wide ? 16'($urandom) : 16'($urandom_range(0, 16'h0FFF));
            bv[i] = wide ? 16'($urandom) : 16'($urandom_range(0, 16'h0FFF));
        end
    endtask

    initial begin
        // Reset state
        #2;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // T1: basic Q8.8 sums
        sv[0] = ONE; sv[1] = ONE << 1; sv[2] = -ONE; sv[3] = 16'h0000;
        for (int i = 0; i < D; i++) bv[i] = ONE >> 1;
        run_vec(1'b0, 1'b0, 1'b0, 1'b0);

        // T2: positive and negative clamps
        sv[0] = 16'h7F00; sv[1] = 16'h8100; sv[2] = 16'h0000; sv[3] = 16'h0100;
        bv[0] = 16'h0200; bv[1] = 16'hFE00; bv[2] = 16'h0010; bv[3] = 16'h0010;
        run_vec(1'b0, 1'b0, 1'b0, 1'b0);

        // T3/T6: gaps, stray valids and ignored start pulses
        fill_random(1'b0);
        run_vec(1'b1, 1'b1, 1'b0, 1'b0);

        // T4: back-to-back vectors, start in the done cycle
        sv[0] = 16'h7000; sv[1] = 16'h9000; sv[2] = 16'h4000; sv[3] = 16'h0001;
        bv[0] = 16'h7000; bv[1] = 16'h9000; bv[2] = 16'h0100; bv[3] = 16'h0001;
        run_vec(1'b0, 1'b0, 1'b0, 1'b1);
        fill_random(1'b1);
        run_vec(1'b0, 1'b1, 1'b1, 1'b0);

        // T5: asynchronous reset part-way through capture
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            skip_in   = 16'($urandom);
            skip_in_v = 1'b1;
            @(negedge clk);
        end
        skip_in_v = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        fill_random(1'b1);
        run_vec(1'b0, 1'b1, 1'b0, 1'b0);

        // Random full-range vectors
        for (int n = 0; n < 6; n++) begin
            fill_random(1'b1);
            run_vec(1'($urandom), 1'($urandom), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
